// File: rtl/des_decryption_unroll4_pkg.sv
`default_nettype none
// ============================================================================
// des_decryption_unroll4_pkg : DES constants, tables and permutation helpers
// Rev 1.0
// ============================================================================
package des_decryption_unroll4_pkg;

    localparam int C_NUM_ROUNDS = 16;
    localparam int C_UNROLL     = 4;
    localparam int C_KEY_W      = 48;
    localparam int C_SCHED_W    = C_NUM_ROUNDS * C_KEY_W;

    // Bit 1 is the MSB everywhere, matching the DES table numbering.
    typedef logic [1:32]        half_t;
    typedef logic [1:48]        subkey_t;
    typedef logic [1:64]        block_t;
    typedef logic [1:C_SCHED_W] sched_t;

    localparam int C_IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int C_IP_INV_TBL [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

    localparam int C_E_TBL [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int C_P_TBL [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    // Each box is stored row-major: index = row*16 + column.
    localparam logic [3:0] C_SBOX [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

    function automatic block_t ip_permutation(input block_t x);
        block_t y;
        for (int i = 1; i <= 64; i++) y[i] = x[C_IP_TBL[i-1]];
        return y;
    endfunction

    function automatic block_t ip_inverse_permutation(input block_t x);
        block_t y;
        for (int i = 1; i <= 64; i++) y[i] = x[C_IP_INV_TBL[i-1]];
        return y;
    endfunction

    function automatic subkey_t e_expansion(input half_t x);
        subkey_t y;
        for (int i = 1; i <= 48; i++) y[i] = x[C_E_TBL[i-1]];
        return y;
    endfunction

    function automatic half_t p_permutation(input half_t x);
        half_t y;
        for (int i = 1; i <= 32; i++) y[i] = x[C_P_TBL[i-1]];
        return y;
    endfunction

    // Outer bits of each 6-bit group select the row, inner four the column.
    function automatic half_t sbox_layer(input subkey_t x);
        half_t      y;
        logic [5:0] six;
        for (int b = 0; b < 8; b++) begin
            six            = x[b*6+1 +: 6];
            y[b*4+1 +: 4]  = C_SBOX[b][{six[5], six[0], six[4:1]}];
        end
        return y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_decryption_unroll4_if.sv
`default_nettype none
// ============================================================================
// des_decryption_unroll4_if : request/response bundle of the DES decrypt core
// Rev 1.0
// ============================================================================
interface des_decryption_unroll4_if;
    import des_decryption_unroll4_pkg::*;

    logic   start;
    block_t ciphertext;
    sched_t round_keys;
    logic   busy;
    logic   done;
    block_t result;

    modport master (output start, ciphertext, round_keys, input busy, done, result);
    modport slave  (input start, ciphertext, round_keys, output busy, done, result);

endinterface
`default_nettype wire

// File: rtl/des_round_comb.sv
`default_nettype none
// ============================================================================
// des_round_comb : one combinational DES Feistel round (L, R, K -> L', R')
// Rev 1.0
// ============================================================================
module des_round_comb
    import des_decryption_unroll4_pkg::*;
(
    input  half_t   l,
    input  half_t   r,
    input  subkey_t k,
    output half_t   l_next,
    output half_t   r_next
);

    half_t w_f;

    assign w_f    = p_permutation(sbox_layer(e_expansion(r) ^ k));
    assign l_next = r;
    assign r_next = l ^ w_f;

endmodule
`default_nettype wire

// File: rtl/des_decryption_unroll4.sv
`default_nettype none
// ============================================================================
// des_decryption_unroll4 : iterative DES decryption, four rounds per clock
// Rev 1.0
// ============================================================================
module des_decryption_unroll4
    import des_decryption_unroll4_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    des_decryption_unroll4_if.slave bus
);

    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_ROUNDS = 2'd1;
    localparam logic [1:0] C_ST_DONE   = 2'd2;
    localparam int         C_GRP_W     = C_UNROLL * C_KEY_W;

    logic [1:0] r_state;
    logic [1:0] r_grp;
    block_t     r_lr;
    block_t     r_result;
    sched_t     r_keys;
    sched_t     w_keys_rev;

    // Decryption walks the schedule backwards: slot 0 holds K16, slot 15 holds K1.
    for (genvar gk = 0; gk < C_NUM_ROUNDS; gk++) begin : g_key_rev
        assign w_keys_rev[gk*C_KEY_W+1 +: C_KEY_W] =
            bus.round_keys[(C_NUM_ROUNDS-1-gk)*C_KEY_W+1 +: C_KEY_W];
    end

    for (genvar gr = 0; gr < C_UNROLL; gr++) begin : g_round
        half_t w_l_in;
        half_t w_r_in;
        half_t w_l_out;
        half_t w_r_out;

        if (gr == 0) begin : g_first
            assign w_l_in = r_lr[1:32];
            assign w_r_in = r_lr[33:64];
        end else begin : g_chain
            assign w_l_in = g_round[gr-1].w_l_out;
            assign w_r_in = g_round[gr-1].w_r_out;
        end

        des_round_comb u_round (
            .l      (w_l_in),
            .r      (w_r_in),
            .k      (r_keys[gr*C_KEY_W+1 +: C_KEY_W]),
            .l_next (w_l_out),
            .r_next (w_r_out)
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= C_ST_IDLE;
            r_grp    <= 2'd0;
            r_result <= '0;
        end else begin
            case (r_state)
                C_ST_IDLE, C_ST_DONE: begin
                    if (bus.start) begin
                        r_lr    <= ip_permutation(bus.ciphertext);
                        r_keys  <= w_keys_rev;
                        r_grp   <= 2'd0;
                        r_state <= C_ST_ROUNDS;
                    end else begin
                        r_state <= C_ST_IDLE;
                    end
                end
                C_ST_ROUNDS: begin
                    r_lr   <= {g_round[C_UNROLL-1].w_l_out, g_round[C_UNROLL-1].w_r_out};
                    r_keys <= {r_keys[C_GRP_W+1:C_SCHED_W], {C_GRP_W{1'b0}}};
                    r_grp  <= r_grp + 2'd1;
                    // Last group: undo the final half-swap and the initial permutation.
                    if (r_grp == 2'd3) begin
                        r_result <= ip_inverse_permutation(
                            {g_round[C_UNROLL-1].w_r_out, g_round[C_UNROLL-1].w_l_out});
                        r_state  <= C_ST_DONE;
                    end
                end
                default: r_state <= C_ST_IDLE;
            endcase
        end
    end

    assign bus.busy   = (r_state == C_ST_ROUNDS);
    assign bus.done   = (r_state == C_ST_DONE);
    assign bus.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_des_decryption_unroll4.sv
`default_nettype none
// ============================================================================
// tb_des_decryption_unroll4 : scoreboard bench with a behavioural DES model
// Rev 1.0
// ============================================================================
module tb_des_decryption_unroll4;
    import des_decryption_unroll4_pkg::*;

    localparam int C_NUM_RANDOM = 1000;

    localparam int C_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int C_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam int C_SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [63:0] C_V1_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] C_V1_CT  = 64'h85E813540F0AB405;
    localparam logic [63:0] C_V1_PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] C_V2_KEY = 64'h0E329232EA6D0D73;
    localparam logic [63:0] C_V2_CT  = 64'h0000000000000000;
    localparam logic [63:0] C_V2_PT  = 64'h8787878787878787;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        mon_en  = 1'b0;
    int          n_vec   = 0;
    int          n_err   = 0;
    logic [63:0] exp_q [$];
    logic [63:0] held    = '0;
    logic [1:768] sched1;
    logic [1:768] sched2;

    des_decryption_unroll4_if bus ();

    des_decryption_unroll4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (textbook DES, MSB = bit 1) -----------
    function automatic logic [1:768] make_schedule(input logic [63:0] key);
        logic [55:0]  cd;
        logic [27:0]  c;
        logic [27:0]  d;
        logic [1:768] s;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-C_PC1[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int n = 0; n < C_SHIFTS[r]; n++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) s[r*48+1+i] = cd[56-C_PC2[i]];
        end
        return s;
    endfunction

    function automatic logic [31:0] ref_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] p;
        logic [5:0]  six;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-C_E_TBL[i]];
        x = x ^ k;
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            s[31-4*b -: 4] = C_SBOX[b][{six[5], six[0], six[4:1]}];
        end
        for (int i = 0; i < 32; i++) p[31-i] = s[32-C_P_TBL[i]];
        return p;
    endfunction

    function automatic logic [63:0] ref_encrypt(input logic [63:0] pt, input logic [1:768] s);
        logic [63:0] ip;
        logic [63:0] pre;
        logic [63:0] out;
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] t;
        for (int i = 0; i < 64; i++) ip[63-i] = pt[64-C_IP_TBL[i]];
        l = ip[63:32];
        r = ip[31:0];
        for (int rnd = 0; rnd < 16; rnd++) begin
            t = r;
            r = l ^ ref_f(r, s[rnd*48+1 +: 48]);
            l = t;
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) out[63-i] = pre[64-C_IP_INV_TBL[i]];
        return out;
    endfunction

    function automatic logic [1:768] rand_bits768();
        logic [1:768] v;
        for (int i = 0; i < 24; i++) v[i*32+1 +: 32] = $urandom();
        return v;
    endfunction

    // ---------------- checking ----------------------------------------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic cyc_check(input string tag, input logic eb, input logic ed);
        @(negedge clk);
        check({tag, "_busy"}, {63'd0, bus.busy}, {63'd0, eb});
        check({tag, "_done"}, {63'd0, bus.done}, {63'd0, ed});
    endtask

    // Scoreboard monitor: pops on each done pulse, otherwise result must be held.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {63'd0, bus.done}, 64'd0);
                end else begin
                    held = exp_q.pop_front();
                    check("result", bus.result, held);
                end
            end else begin
                check("result_hold", bus.result, held);
            end
            if (rst) held = '0;
        end
    end

    // ---------------- stimulus ----------------------------------------------
    task automatic run_block(input logic [63:0] ct, input logic [1:768] keys, input logic [63:0] pt);
        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.ciphertext = ct;
        bus.round_keys = keys;
        exp_q.push_back(pt);
        @(posedge clk); #1;
        bus.start      = 1'b0;
        bus.ciphertext = {$urandom(), $urandom()};
        bus.round_keys = rand_bits768();
        for (int c = 1; c <= 5; c++) cyc_check("latency", c <= 4, c == 5);
    endtask

    initial begin
        logic [63:0]  key;
        logic [63:0]  pt;
        logic [1:768] s;

        bus.start      = 1'b0;
        bus.ciphertext = '0;
        bus.round_keys = '0;
        sched1 = make_schedule(C_V1_KEY);
        sched2 = make_schedule(C_V2_KEY);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        cyc_check("reset", 1'b0, 1'b0);
        check("reset_result", bus.result, 64'd0);

        run_block(C_V1_CT, sched1, C_V1_PT);
        run_block(C_V2_CT, sched2, C_V2_PT);

        // Back-to-back: start held through the rounds, second block loaded in DONE.
        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.ciphertext = C_V1_CT;
        bus.round_keys = sched1;
        exp_q.push_back(C_V1_PT);
        exp_q.push_back(C_V2_PT);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c <= 4) begin
                bus.start      = 1'b1;
                bus.ciphertext = {$urandom(), $urandom()};
                bus.round_keys = rand_bits768();
            end else if (c == 5) begin
                bus.start      = 1'b1;
                bus.ciphertext = C_V2_CT;
                bus.round_keys = sched2;
            end else begin
                bus.start      = 1'b0;
            end
            cyc_check("b2b", (c <= 4) || (c >= 6 && c <= 9), (c == 5) || (c == 10));
        end

        // Reset in cycle 3 of an operation aborts it.
        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.ciphertext = C_V1_CT;
        bus.round_keys = sched1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc_check("midrst_c1", 1'b1, 1'b0);
        @(posedge clk); #1;
        cyc_check("midrst_c2", 1'b1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        cyc_check("midrst_c3", 1'b1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc_check("midrst_c4", 1'b0, 1'b0);
        check("midrst_result", bus.result, 64'd0);
        run_block(C_V2_CT, sched2, C_V2_PT);

        // Start coincident with reset is dropped.
        @(posedge clk); #1;
        rst            = 1'b1;
        bus.start      = 1'b1;
        bus.ciphertext = C_V1_CT;
        bus.round_keys = sched1;
        @(posedge clk); #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        for (int c = 1; c <= 8; c++) cyc_check("rst_start", 1'b0, 1'b0);
        check("rst_start_result", bus.result, 64'd0);

        // Loopback: random key/plaintext, encrypted by the model, decrypted by the DUT.
        for (int n = 0; n < C_NUM_RANDOM; n++) begin
            key = {$urandom(), $urandom()};
            pt  = {$urandom(), $urandom()};
            s   = make_schedule(key);
            run_block(ref_encrypt(pt, s), s, pt);
        end

        @(negedge clk);
        check("pending_results", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/des_decryption_unroll4.md
# des_decryption_unroll4

Iterative DES decryption core with four rounds unrolled per clock. It accepts a 64-bit ciphertext and the full 16-entry round-key schedule in encryption order (K1 first), then applies K16..K1 internally. It returns the plaintext after a fixed 5-cycle latency. It is the inverse-direction companion to the team's 4-round-unrolled DES encryption core and uses the same key-schedule bus format, so the two cores can share one key-schedule generator.

## Interface
- No parameters. Round count (16), unroll factor (4) and widths are fixed constants.
- clk  input  1  rising-edge clock, the single clock domain.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request pulse. Sampled only in IDLE or DONE; ignored otherwise.
- ciphertext  input  [1:64]  block to decrypt. Sampled with start.
- round_keys  input  [1:768]  K1 at [1:48], K2 at [49:96], … K16 at [721:768]. Sampled with start.
- busy  output  1  high while rounds are in progress.
- done  output  1  one-cycle pulse: result is valid.
- result  output  [1:64]  plaintext. Registered, held until the next accepted start or reset.

## Operation
- States:
  - IDLE (reset state).
  - ROUNDS, with a 2-bit group counter g = 0..3.
  - DONE.
- Start acceptance in IDLE or DONE with start=1:
  - Load LR <= IP(ciphertext).
  - Load key register with the schedule reversed per 48-bit entry (K16 in the first slot … K1 in the last).
  - Clear g; go to ROUNDS.
- ROUNDS, each cycle:
  - Pass LR through four chained combinational rounds using keys K(16-4g), K(15-4g), K(14-4g), K(13-4g).
  - Round definition: L' = R, R' = L xor f(R, K); f = P(S(E(R) xor K)).
  - Store the 4-round output in LR.
  - Shift the key register left by 192 bits.
  - g increments.
- Exit from ROUNDS: in the cycle with g = 3, the result register loads IP⁻¹({R16, L16}) (final half-swap) and the state moves to DONE.
- DONE: done=1 for exactly this cycle.
  - Next state is ROUNDS if start=1 (back-to-back acceptance), otherwise IDLE.
- start in ROUNDS: ignored. No reload, no abort.
- Key order is the only functional difference from encryption. Supplying a reversed schedule must not be required of the user.

## Timing
- Reset values: busy=0, done=0, result=64'h0, state IDLE, g=0. LR and key register are don't-care.
- Latency: start sampled high at the end of cycle 0 → busy high in cycles 1–4 → done high and result valid in cycle 5.
- Throughput: one block per 5 cycles with start held or re-pulsed in each DONE cycle.
- Back-to-back start in DONE:
  - result keeps the previous plaintext during the new rounds until the new load.
  - done is low in cycles 6–9 and pulses again in cycle 10.
- rst=1 in any cycle, including mid-ROUNDS or DONE, overrides everything:
  - Next cycle is IDLE with all outputs at reset values.
  - A start coincident with rst is dropped.
- Inputs need only be stable in the start cycle, since they are captured.
- Critical path: four cascaded rounds between LR flops. This is the same depth as the encryption core, and both must close at the same target frequency.

## Structure
- Shared DES include/package, also used by the encryption core:
  - IP and IP⁻¹ permutations (existing primitives ip_permutation, ip_inverse_permutation).
  - E expansion, P permutation, S-box tables.
  - Constants: round count 16, unroll factor 4, key entry width 48.
- Sub-module des_round_comb: purely combinational single round (L, R, K → L', R'). Instantiate it four times in a chain.
- FSM, counter, key-reversal wiring and registers live in the top module. Key reversal is wiring only, with no extra cycle.

## Test plan
- Standard vector:
  - Stimulus: schedule of key 133457799BBCDFF1, ciphertext 85E813540F0AB405, start pulse.
  - Required: busy high in cycles 1–4; done pulses only in cycle 5; result = 0123456789ABCDEF.
- Second vector:
  - Stimulus: key 0E329232EA6D0D73, ciphertext 0000000000000000.
  - Required: result = 8787878787878787.
- Loopback against the encryption core: 1000 random key/plaintext pairs, encrypt then decrypt with the same round_keys bus → result equals the original plaintext.
- Back-to-back:
  - Stimulus: start held high across vectors 1 and 2.
  - Required: done pulses in cycles 5 and 10; result changes only at those cycles; start in cycles 1–4 has no effect.
- Mid-operation reset:
  - Stimulus: rst=1 in cycle 3 after start.
  - Required: cycle 4 shows busy=0, done=0, result=0.
  - A fresh start then completes normally with the correct plaintext 5 cycles later.
- Reset coincident with start → stays IDLE; no done pulse ever follows.
